// File: rtl/rx_rcu_if.sv
// Signal bundle between the UART receive control unit and its neighbours
// (line input, shift register, receive data buffer).
interface rx_rcu_if;
    logic serial_in;
    logic stop_bit;
    logic shift_strobe;
    logic load_buffer;
    logic framing_error;
    logic rx_busy;

    modport master (
        output serial_in, stop_bit,
        input  shift_strobe, load_buffer, framing_error, rx_busy
    );

    modport slave (
        input  serial_in, stop_bit,
        output shift_strobe, load_buffer, framing_error, rx_busy
    );
endinterface

// File: rtl/rx_rcu_timer.sv
// UART receive control unit: start-bit detection, mid-bit strobing of 9 bits,
// stop-bit check. CLKS_PER_BIT must be even and >= 4.
module rx_rcu_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BITS     = 9
) (
    input  logic   clk,
    input  logic   rst,
    rx_rcu_if.slave bus
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [3:0]    LAST_BIT = 4'(NUM_BITS - 1);

    typedef enum logic [2:0] {IDLE, START_WAIT, RECEIVE, STOP_CHK, LOAD} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic          fe, fe_nxt;
    logic          strobe;

    assign strobe = (state == RECEIVE) && (timer == T_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            fe      <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
            fe      <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = '0;
        bit_cnt_nxt = bit_cnt;
        fe_nxt      = fe;
        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                // Level-sensitive on purpose: a held-low line restarts a frame.
                if (!bus.serial_in) begin
                    state_nxt = START_WAIT;
                    timer_nxt = T_ONE;
                end
            end
            START_WAIT: begin
                timer_nxt = timer + T_ONE;
                if (timer == T_HALF) begin
                    if (bus.serial_in) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = RECEIVE;
                        timer_nxt = T_ONE;
                        fe_nxt    = 1'b0;
                    end
                end
            end
            RECEIVE: begin
                timer_nxt = (timer == T_FULL) ? T_ONE : timer + T_ONE;
                if (strobe) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = STOP_CHK;
                        timer_nxt = '0;
                    end
                end
            end
            STOP_CHK: begin
                // stop_bit already holds the 9th shifted bit in this cycle
                if (bus.stop_bit) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                    fe_nxt    = 1'b1;
                end
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.shift_strobe  = strobe;
    assign bus.load_buffer   = (state == LOAD);
    assign bus.framing_error = fe;
    assign bus.rx_busy       = (state != IDLE);
endmodule

// File: tb/tb_rx_rcu_timer.sv
// Bench for rx_rcu_timer: line driver, 9-bit shift register and buffer model,
// and an event scoreboard with exact cycle expectations.
module tb_rx_rcu_timer;
    localparam int C = 10;
    localparam int EV_STB  = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_RISE = 2;
    localparam int EV_FALL = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   fe_model = 1'b0;
    logic prev_fe = 1'b0;
    logic [8:0] sr = '0;
    ev_t  exp_q[$];

    rx_rcu_if bus();

    rx_rcu_timer #(.CLKS_PER_BIT(C), .NUM_BITS(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // shift register: LSB-first, stop bit ends up in bit 8
    always @(posedge clk) if (bus.shift_strobe) sr <= {bus.serial_in, sr[8:1]};
    assign bus.stop_bit = sr[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input logic [7:0] d);
        ev_t ev;
        ev.kind = kind;
        ev.cyc  = at;
        ev.data = d;
        exp_q.push_back(ev);
    endtask

    task automatic got(input int kind, input logic [7:0] d);
        ev_t ev;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got unexpected kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != kind || ev.cyc != cyc || (kind == EV_LOAD && ev.data !== d)) begin
                fails++;
                $display("FAIL event: got kind %0d cycle %0d data %0h, expected kind %0d cycle %0d data %0h",
                         kind, cyc, d, ev.kind, ev.cyc, ev.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.shift_strobe) got(EV_STB, 8'h00);
            if (bus.load_buffer) got(EV_LOAD, sr[7:0]);
            if (bus.framing_error === 1'b1 && prev_fe === 1'b0) got(EV_RISE, 8'h00);
            if (bus.framing_error === 1'b0 && prev_fe === 1'b1) got(EV_FALL, 8'h00);
        end
        prev_fe <= bus.framing_error;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting this cycle (e); abort_at>0 resets at e+abort_at.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input int abort_at);
        int e;
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        e = cyc;
        if (fe_model) push(EV_FALL, e + C/2 + 1, 8'h00);
        fe_model = 1'b0;
        for (int k = 0; k < 9; k++)
            if (abort_at == 0 || e + C/2 + (k+1)*C <= e + abort_at)
                push(EV_STB, e + C/2 + (k+1)*C, 8'h00);
        if (abort_at == 0) begin
            if (stop) push(EV_LOAD, e + C/2 + 9*C + 2, d);
            else begin
                push(EV_RISE, e + C/2 + 9*C + 2, 8'h00);
                fe_model = 1'b1;
            end
        end
        for (int t = 0; t < 10*C; t++) begin
            if (abort_at != 0 && t == abort_at) begin
                rst = 1'b1;
                bus.serial_in = 1'b1;
                wait_cyc(1);
                rst = 1'b0;
                @(negedge clk);
                chk("rst_mid_busy", bus.rx_busy, 1'b0);
                chk("rst_mid_strobe", bus.shift_strobe, 1'b0);
                break;
            end
            bus.serial_in = bits[t/C];
            wait_cyc(1);
        end
        bus.serial_in = 1'b1;
        wait_cyc(gap);
    endtask

    initial begin
        vec_t tbl[6];
        int   e;
        tbl[0] = '{8'hA5, 1'b1, 0};
        tbl[1] = '{8'hA5, 1'b0, 20};
        tbl[2] = '{8'h3C, 1'b1, 0};
        tbl[3] = '{8'hFF, 1'b1, 0};
        tbl[4] = '{8'h00, 1'b1, 7};
        tbl[5] = '{8'h81, 1'b0, 20};

        rst = 1'b1;
        bus.serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_strobe", bus.shift_strobe, 1'b0);
        chk("rst_load", bus.load_buffer, 1'b0);
        chk("rst_fe", bus.framing_error, 1'b0);
        chk("rst_busy", bus.rx_busy, 1'b0);
        mon_en = 1'b1;
        wait_cyc(50);
        chk("idle_busy", bus.rx_busy, 1'b0);

        for (int i = 0; i < 6; i++)
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, 0);
        chk("fe_sticky", bus.framing_error, 1'b1);

        // glitch: 3 low cycles, rejected at mid-bit, error flag untouched
        e = cyc;
        bus.serial_in = 1'b0;
        wait_cyc(3);
        bus.serial_in = 1'b1;
        wait_cyc(2);
        @(negedge clk);
        chk("glitch_busy_e5", bus.rx_busy, 1'b1);
        chk("glitch_cycle", cyc - e, 5);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("glitch_busy_e6", bus.rx_busy, 1'b0);
        chk("glitch_fe_kept", bus.framing_error, 1'b1);
        wait_cyc(20);

        send_frame(8'h96, 1'b1, 60, 50);
        chk("post_rst_busy", bus.rx_busy, 1'b0);
        send_frame(8'hC3, 1'b1, 30, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        chk("end_busy", bus.rx_busy, 1'b0);
        chk("end_fe", bus.framing_error, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/rx_rcu_timer.md
Name: rx_rcu_timer

Overview:
- UART receive control unit with an integrated bit-period timer.
- Sits directly upstream of the 9-bit receive shift register (8 data + stop bit).
- Detects the start bit and confirms it at mid-bit, then issues one shift_strobe per bit at the centre of each data/stop bit.
- After the frame, checks the stop bit returned by the shift register and either pulses load_buffer to the receive data buffer or flags a framing error.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit; must be even and >= 4.
- NUM_BITS, 9, strobes per frame (8 data + 1 stop); fixed at 9 for this design.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high. Same base name as the codebase reset, without the n_ prefix because polarity is high.
- serial_in  input  1  receive line, already synchronized to clk, idle high.
- stop_bit  input  1  stop bit from the shift register (bit 8 of its parallel output).
- shift_strobe  output  1  one-cycle pulse; the shift register samples serial_in on this cycle.
- load_buffer  output  1  one-cycle pulse; the data buffer captures packet_data.
- framing_error  output  1  level; set when the received stop bit is 0.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; timer and bit_cnt go to 0.
  - All outputs are 0 the following cycle.
  - Reset mid-frame abandons the frame; no strobe or load is issued afterwards.
- Timer:
  - Width $clog2(CLKS_PER_BIT+1).
  - Reads 1 in the first cycle of START_WAIT and of RECEIVE; increments each cycle.
  - In RECEIVE it wraps to 1 on the cycle after it reads CLKS_PER_BIT.
- Bit counter: 4-bit, increments on each shift_strobe, cleared in IDLE.
- States and transitions:
  - IDLE: serial_in==0 -> START_WAIT. Level-triggered: a held-low line (break) re-triggers each frame and yields framing errors.
  - START_WAIT, when timer==CLKS_PER_BIT/2:
    - serial_in==0 -> RECEIVE; framing_error is cleared here.
    - serial_in==1 -> IDLE (glitch rejected; no strobe; framing_error unchanged).
  - RECEIVE:
    - shift_strobe=1 in any cycle with timer==CLKS_PER_BIT.
    - On the strobe where bit_cnt==NUM_BITS-1 -> STOP_CHK.
  - STOP_CHK, one cycle; stop_bit now reflects the 9th shifted bit:
    - stop_bit==1 -> LOAD.
    - stop_bit==0 -> IDLE with framing_error set (registered, visible next cycle).
  - LOAD, one cycle: load_buffer=1 -> IDLE.
- Outputs are Moore, decoded from the registered state and timer; no combinational path from serial_in to any output.
- Timing, with e = the IDLE cycle in which serial_in==0 is sampled and C = CLKS_PER_BIT:
  - START_WAIT occupies e+1 .. e+C/2.
  - Strobe k (k = 0..8) occurs at e + C/2 + (k+1)*C.
  - STOP_CHK at e + C/2 + 9C + 1.
  - LOAD (or framing_error rising) one cycle after STOP_CHK.
  - For C=10: strobes at e+15, e+25, …, e+95; STOP_CHK at e+96; load_buffer or framing_error at e+97; IDLE at e+98 or e+97 respectively.
- rx_busy: high from e+1 through the last non-IDLE cycle.
- Back-to-back frames: the next start edge arrives >= C/2 cycles after the stop-bit midpoint, so the FSM is back in IDLE in time. serial_in is ignored outside IDLE/START_WAIT except at strobe sampling (which happens in the shift register).
- framing_error is sticky: it holds across IDLE until the next confirmed start bit or reset. It never asserts in the same frame as load_buffer.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, serial_in=1 for 50 cycles -> all outputs 0, no strobes.
- Valid frame 0xA5, C=10: start low at e, LSB-first data, stop=1, each bit 10 cycles; shift register model attached.
  - Expect exactly 9 strobes at e+15 + 10k.
  - load_buffer single pulse at e+97; packet_data=0xA5; framing_error=0.
- Framing error: same frame with stop=0.
  - Expect 9 strobes and no load_buffer.
  - framing_error=1 from e+97, held until the next frame's start confirmation at e'+5.
- Glitch: serial_in low for 3 cycles only -> START_WAIT aborts at e+5; no strobes; rx_busy low from e+6.
- Back-to-back: frames 0x3C then 0xFF with no idle gap -> two load_buffer pulses exactly 100 cycles apart, correct data each.
- Mid-frame reset: assert rst at e+50 -> from e+51 state IDLE, no further strobes or load; a subsequent clean frame is received correctly.
